vec_execute_unit: RTL and testbench
===================================

// Module: vec_execute_unit
// PURPOSE
//  Parametrised vector execute unit; successor to the scalar execute stage. Sits between DE and MEM on the vector path.
//  Executes LANES-wide integer vector ops: single-cycle ALU ops, plus an iterative multi-cycle VMUL.
//  Uses a valid/ready handshake upstream and honours a downstream stall from the GPU stage.
// PARAMETERS
//  LANES       4   lane count; power of two, >=2
//  LANE_WIDTH  16  bits per lane
//  VREG_IDW    6   vector destination register index width
// PORTS
//  I_CLOCK        in   1                  clock; all state updates on negedge, matching the pipeline
//  I_RESET_N      in   1                  asynchronous active-low reset
//  I_Valid        in   1                  DE presents an op this cycle
//  O_Ready        out  1                  unit accepts the op this cycle
//  I_Op           in   3                  VADD=0 VSUB=1 VAND=2 VMOVI=3 VCOMPMOV=4 VMUL=5; 6,7 reserved
//  I_Idx          in   $clog2(LANES)      target lane for VCOMPMOV
//  I_VecSrc1      in   LANES*LANE_WIDTH   vector operand A; lane i = bits [i*LANE_WIDTH +: LANE_WIDTH]
//  I_VecSrc2      in   LANES*LANE_WIDTH   vector operand B
//  I_Scalar       in   LANE_WIDTH         immediate/scalar for VMOVI and VCOMPMOV
//  I_DestVRegIdx  in   VREG_IDW           destination vector register
//  I_GPUStall     in   1                  downstream cannot take a result
//  O_Valid        out  1                  O_VecDest holds a result
//  O_VecDest      out  LANES*LANE_WIDTH   result vector
//  O_DestVRegIdx  out  VREG_IDW           destination vector register of the result
//  O_VRegWEn      out  1                  equals O_Valid && op writes a register; 0 for reserved ops
//  O_Busy         out  1                  VMUL in flight; DE uses it for dependency stall
// BEHAVIOUR
//  - Reset: every output is 0; state = IDLE; O_Ready follows its equation once reset is released.
//  - Handshake: an op is accepted when I_Valid && O_Ready.
//  - O_Ready = (state==IDLE) && !(O_Valid && I_GPUStall).
//  - States IDLE, MUL. The output register holds the result; no separate HOLD state.
//  - IDLE, non-VMUL accept:
//    - Result is registered at the next edge; O_Valid=1 (latency 1).
//    - Back-to-back accepts give one result per cycle.
//  - IDLE, VMUL accept:
//    - Go to MUL; O_Busy=1; counter = LANE_WIDTH-1.
//    - Lanes do radix-2 shift-add in parallel, one bit per cycle.
//    - When the counter reaches 0: load the result, O_Valid=1, return to IDLE.
//    - Latency LANE_WIDTH+1 edges from accept. Only the low LANE_WIDTH bits of each product are kept.
//  - Result consumption: O_Valid clears at the next edge unless I_GPUStall=1; while stalled, O_VecDest, O_DestVRegIdx and O_VRegWEn hold.
//  - VMUL done while stalled: the result stays in the MUL datapath and is presented one cycle after the stall drops. It never overwrites a held result.
//  - Arithmetic:
//    - VADD/VSUB are lane-wise, wrapping modulo 2^LANE_WIDTH; no cross-lane carry.
//    - VAND is bitwise.
//    - VMOVI broadcasts I_Scalar to all lanes.
//    - VCOMPMOV = I_VecSrc1 with lane I_Idx replaced by I_Scalar.
//  - Reserved opcodes are accepted with O_Valid=1, O_VRegWEn=0, O_VecDest=0.
//  - I_Valid while !O_Ready is ignored; DE must hold its inputs.
//  - Reset mid-VMUL aborts the op; no result is produced.
// CONFIGURATION
//  - VEC_EXEC_SATURATE_EN defined: VADD/VSUB saturate per lane as signed (0x7FFF / 0x8000 at 16 bits).
//  - Undefined: VADD/VSUB wrap. VMUL is unaffected either way.
// STRUCTURE
//  - Package vec_exec_pkg: opcode localparams, state enum, lane slice helper function.
//  - Sub-module vec_lane_mul (LANE_WIDTH): iterative shift-add multiplier, instantiated LANES times by generate.
// TESTING (LANES=4, LANE_WIDTH=16)
//  - VADD, Src1 lanes {1,2,3,0xFFFF}, Src2 all 1 -> next cycle {2,3,4,0x0000}, O_VRegWEn=1.
//    - Same with VEC_EXEC_SATURATE_EN -> lane3 = 0x0000 (-1+1).
//    - {0x7FFF}+1 -> 0x7FFF.
//  - VCOMPMOV, Src1=0, Idx=2, Scalar=0xABCD -> lane2=0xABCD, other lanes 0. VMOVI Scalar=5 -> all lanes 5.
//  - VMUL, lanes {3,7,0x100,0xFFFF} x {5,9,0x100,2} -> after 17 edges {15,63,0x0000,0xFFFE}.
//    - O_Ready=0 and O_Busy=1 throughout.
//  - I_GPUStall=1 for 3 cycles with a result valid -> result held 3 cycles, O_Ready=0.
//    - A VMUL finishing under stall is presented the cycle after release.
//  - Assert I_RESET_N=0 mid-VMUL (cycle 6) -> all outputs 0 immediately; after release O_Ready=1 and no stale result appears.
//  - Four back-to-back VAND ops with no stall -> four consecutive O_Valid cycles in order, correct O_DestVRegIdx each.

Source files
------------

// File: rtl/vec_exec_pkg.sv
// ---------------------------------------------------------------------------
// vec_exec_pkg
//   Shared definitions for the vector execute unit: opcode encodings, the
//   control FSM state type and a helper that locates a lane inside a packed
//   vector.
// ---------------------------------------------------------------------------
package vec_exec_pkg;

   localparam logic [2:0] OP_VADD     = 3'd0;
   localparam logic [2:0] OP_VSUB     = 3'd1;
   localparam logic [2:0] OP_VAND     = 3'd2;
   localparam logic [2:0] OP_VMOVI    = 3'd3;
   localparam logic [2:0] OP_VCOMPMOV = 3'd4;
   localparam logic [2:0] OP_VMUL     = 3'd5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Bit position of the least significant bit of a lane in a packed vector.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/vec_lane_mul.sv
// ---------------------------------------------------------------------------
// vec_lane_mul
//   One lane of the iterative radix-2 shift-add multiplier. Each step adds the
//   shifted multiplicand when the current multiplier LSB is set, so a full
//   product takes LANE_WIDTH steps. Only the low LANE_WIDTH bits are kept.
//
// Ports
//   clk        in   clock, state updates on the falling edge
//   load       in   capture operands and clear the accumulator
//   step       in   perform one shift-add iteration
//   a, b       in   multiplicand / multiplier (LANE_WIDTH)
//   prod       out  accumulator (final product once all steps are done)
//   prod_next  out  accumulator value after the current step
// ---------------------------------------------------------------------------
module vec_lane_mul #(
   parameter int LANE_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  load,
   input  logic                  step,
   input  logic [LANE_WIDTH-1:0] a,
   input  logic [LANE_WIDTH-1:0] b,
   output logic [LANE_WIDTH-1:0] prod,
   output logic [LANE_WIDTH-1:0] prod_next
);

   logic [LANE_WIDTH-1:0] mcand_p0;
   logic [LANE_WIDTH-1:0] mplier_p0;
   logic [LANE_WIDTH-1:0] acc_p0;

   assign prod_next = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
   assign prod      = acc_p0;

   // Datapath only: a fresh load always precedes use, so no reset needed.
   always_ff @(negedge clk) begin
      if (load) begin
         acc_p0    <= '0;
         mcand_p0  <= a;
         mplier_p0 <= b;
      end else if (step) begin
         acc_p0    <= prod_next;
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
      end
   end

endmodule

// File: rtl/vec_execute_unit.sv
// ---------------------------------------------------------------------------
// vec_execute_unit
//   LANES-wide integer vector execute stage between DE and MEM. Single-cycle
//   lane-wise ALU ops (VADD, VSUB, VAND, VMOVI, VCOMPMOV) and an iterative
//   VMUL that runs LANE_WIDTH shift-add steps in all lanes in parallel.
//   All state changes on the falling clock edge.
//
// Build option
//   VEC_EXEC_SATURATE_EN : when defined, VADD/VSUB saturate per lane as
//                          signed values; otherwise they wrap.
//
// Ports
//   I_CLOCK        in   clock
//   I_RESET_N      in   asynchronous active-low reset
//   I_Valid        in   DE presents an op
//   O_Ready        out  op accepted this cycle when I_Valid is also high
//   I_Op           in   opcode (6,7 reserved)
//   I_Idx          in   target lane for VCOMPMOV
//   I_VecSrc1/2    in   vector operands
//   I_Scalar       in   scalar for VMOVI / VCOMPMOV
//   I_DestVRegIdx  in   destination vector register
//   I_GPUStall     in   downstream cannot take a result
//   O_Valid        out  result present
//   O_VecDest      out  result vector
//   O_DestVRegIdx  out  destination register of the result
//   O_VRegWEn      out  result writes a register
//   O_Busy         out  VMUL in flight
// ---------------------------------------------------------------------------
module vec_execute_unit
   import vec_exec_pkg::*;
#(
   parameter int LANES      = 4,
   parameter int LANE_WIDTH = 16,
   parameter int VREG_IDW   = 6
) (
   input  logic                        I_CLOCK,
   input  logic                        I_RESET_N,
   input  logic                        I_Valid,
   output logic                        O_Ready,
   input  logic [2:0]                  I_Op,
   input  logic [$clog2(LANES)-1:0]    I_Idx,
   input  logic [LANES*LANE_WIDTH-1:0] I_VecSrc1,
   input  logic [LANES*LANE_WIDTH-1:0] I_VecSrc2,
   input  logic [LANE_WIDTH-1:0]       I_Scalar,
   input  logic [VREG_IDW-1:0]         I_DestVRegIdx,
   input  logic                        I_GPUStall,
   output logic                        O_Valid,
   output logic [LANES*LANE_WIDTH-1:0] O_VecDest,
   output logic [VREG_IDW-1:0]         O_DestVRegIdx,
   output logic                        O_VRegWEn,
   output logic                        O_Busy
);

   localparam int VEC_W = LANES * LANE_WIDTH;
   localparam int IDX_W = $clog2(LANES);
   localparam int CNT_W = (LANE_WIDTH > 2) ? $clog2(LANE_WIDTH) : 1;

`ifdef VEC_EXEC_SATURATE_EN
   // Clamp a LANE_WIDTH+1 bit signed sum to the signed lane range.
   function automatic logic [LANE_WIDTH-1:0] sat_lane(input logic [LANE_WIDTH:0] s);
      if (s[LANE_WIDTH] != s[LANE_WIDTH-1])
         return s[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
                              : {1'b0, {(LANE_WIDTH-1){1'b1}}};
      return s[LANE_WIDTH-1:0];
   endfunction
`endif

   function automatic logic [LANE_WIDTH-1:0] lane_add(input logic signed [LANE_WIDTH-1:0] x,
                                                       input logic signed [LANE_WIDTH-1:0] y);
`ifdef VEC_EXEC_SATURATE_EN
      return sat_lane({x[LANE_WIDTH-1], x} + {y[LANE_WIDTH-1], y});
`else
      return x + y;
`endif
   endfunction

   function automatic logic [LANE_WIDTH-1:0] lane_sub(input logic signed [LANE_WIDTH-1:0] x,
                                                       input logic signed [LANE_WIDTH-1:0] y);
`ifdef VEC_EXEC_SATURATE_EN
      return sat_lane({x[LANE_WIDTH-1], x} - {y[LANE_WIDTH-1], y});
`else
      return x - y;
`endif
   endfunction

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic               done;       // final product parked behind a stall
   logic               accept;
   logic               mul_load, mul_step, mul_fin, mul_park;
   logic [VEC_W-1:0]   alu_res;
   logic               alu_wen;
   logic [VEC_W-1:0]   mul_acc, mul_nxt, mul_res;
   logic [VREG_IDW-1:0] mul_idx;

   logic               vld_p0;
   logic [VEC_W-1:0]   res_p0;
   logic [VREG_IDW-1:0] idx_p0;
   logic               wen_p0;

   assign O_Ready = I_RESET_N && (state == ST_IDLE) && !(vld_p0 && I_GPUStall);
   assign accept  = I_Valid && O_Ready;
   assign O_Busy  = (state == ST_MUL);

   // Per-lane ALU and multiplier.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [LANE_WIDTH-1:0] a, b, r;

      assign a = I_VecSrc1[lane_lsb(g, LANE_WIDTH) +: LANE_WIDTH];
      assign b = I_VecSrc2[lane_lsb(g, LANE_WIDTH) +: LANE_WIDTH];

      always_comb begin
         r = '0;
         case (I_Op)
            OP_VADD:     r = lane_add(a, b);
            OP_VSUB:     r = lane_sub(a, b);
            OP_VAND:     r = a & b;
            OP_VMOVI:    r = I_Scalar;
            OP_VCOMPMOV: r = (I_Idx == IDX_W'(g)) ? I_Scalar : a;
            default:     r = '0;   // VMUL comes from the multiplier; reserved ops yield 0
         endcase
      end

      assign alu_res[lane_lsb(g, LANE_WIDTH) +: LANE_WIDTH] = r;

      vec_lane_mul #(.LANE_WIDTH(LANE_WIDTH)) u_mul (
         .clk       (I_CLOCK),
         .load      (mul_load),
         .step      (mul_step),
         .a         (a),
         .b         (b),
         .prod      (mul_acc[lane_lsb(g, LANE_WIDTH) +: LANE_WIDTH]),
         .prod_next (mul_nxt[lane_lsb(g, LANE_WIDTH) +: LANE_WIDTH])
      );
   end

   assign alu_wen = (I_Op <= OP_VMUL);
   // The last step's sum is taken combinationally so VMUL needs no extra cycle.
   assign mul_res = done ? mul_acc : mul_nxt;

   // ---- control FSM: state register ----
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // ---- control FSM: next state and multiplier strobes ----
   // A finished product is only presented while downstream is not stalling;
   // otherwise it parks in the multiplier and the FSM stays in MUL.
   always_comb begin
      state_nxt = state;
      mul_load  = 1'b0;
      mul_step  = 1'b0;
      mul_fin   = 1'b0;
      mul_park  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept && I_Op == OP_VMUL) begin
               mul_load  = 1'b1;
               state_nxt = ST_MUL;
            end
         end
         ST_MUL: begin
            if (done) begin
               if (!I_GPUStall) begin
                  mul_fin   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end else begin
               mul_step = 1'b1;
               if (cnt == '0) begin
                  if (!I_GPUStall) begin
                     mul_fin   = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     mul_park = 1'b1;
                  end
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---- iteration counter and parked flag ----
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         if (mul_load)
            cnt <= CNT_W'(LANE_WIDTH - 1);
         else if (mul_step && cnt != '0)
            cnt <= cnt - 1'b1;

         if (mul_load || mul_fin) done <= 1'b0;
         else if (mul_park)       done <= 1'b1;
      end
   end

   always_ff @(negedge I_CLOCK) begin
      if (mul_load) mul_idx <= I_DestVRegIdx;
   end

   // ---- stage p0: output register ----
   always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         vld_p0 <= 1'b0;
         res_p0 <= '0;
         idx_p0 <= '0;
         wen_p0 <= 1'b0;
      end else if (accept && I_Op != OP_VMUL) begin
         vld_p0 <= 1'b1;
         res_p0 <= alu_res;
         idx_p0 <= I_DestVRegIdx;
         wen_p0 <= alu_wen;
      end else if (mul_fin) begin
         vld_p0 <= 1'b1;
         res_p0 <= mul_res;
         idx_p0 <= mul_idx;
         wen_p0 <= 1'b1;
      end else if (vld_p0 && !I_GPUStall) begin
         vld_p0 <= 1'b0;
         wen_p0 <= 1'b0;
      end
   end

   assign O_Valid       = vld_p0;
   assign O_VecDest     = res_p0;
   assign O_DestVRegIdx = idx_p0;
   assign O_VRegWEn     = wen_p0;

endmodule

// File: tb/tb_vec_execute_unit.sv
module tb_vec_execute_unit;
   import vec_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        ready;
   logic [2:0]  op;
   logic [1:0]  idx;
   logic [63:0] src1, src2;
   logic [15:0] scalar;
   logic [5:0]  dst;
   logic        stall;
   logic        out_valid;
   logic [63:0] vec_dest;
   logic [5:0]  dest_idx;
   logic        wen;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cnt_ok;
   int cnt_v;

   always #5 clk = ~clk;

   vec_execute_unit #(.LANES(4), .LANE_WIDTH(16), .VREG_IDW(6)) dut (
      .I_CLOCK       (clk),
      .I_RESET_N     (rst_n),
      .I_Valid       (in_valid),
      .O_Ready       (ready),
      .I_Op          (op),
      .I_Idx         (idx),
      .I_VecSrc1     (src1),
      .I_VecSrc2     (src2),
      .I_Scalar      (scalar),
      .I_DestVRegIdx (dst),
      .I_GPUStall    (stall),
      .O_Valid       (out_valid),
      .O_VecDest     (vec_dest),
      .O_DestVRegIdx (dest_idx),
      .O_VRegWEn     (wen),
      .O_Busy        (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance past one falling edge; lands 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [15:0] s, input logic [1:0] ix, input logic [5:0] d);
      in_valid = 1'b1; op = o; src1 = a; src2 = b; scalar = s; idx = ix; dst = d;
      tick();
      in_valid = 1'b0;
   endtask

   logic [63:0] vand_b   [4];
   logic [63:0] vand_exp [4];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vand_b[0] = 64'hFFFF_0000_FFFF_0000; vand_exp[0] = 64'h1234_0000_9ABC_0000;
      vand_b[1] = 64'h0000_FFFF_0000_FFFF; vand_exp[1] = 64'h0000_5678_0000_DEF0;
      vand_b[2] = 64'h0F0F_0F0F_0F0F_0F0F; vand_exp[2] = 64'h0204_0608_0A0C_0E00;
      vand_b[3] = 64'hF00F_F00F_F00F_F00F; vand_exp[3] = 64'h1004_5008_900C_D000;

      rst_n = 1'b1; in_valid = 1'b0; op = '0; idx = '0; src1 = '0; src2 = '0;
      scalar = '0; dst = '0; stall = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", ready, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_wen",   wen, 0);
      chk("rst_dest",  vec_dest, 0);
      chk("rst_idx",   dest_idx, 0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", ready, 1);

      // VADD with wrap on lane 3
      issue(OP_VADD, 64'hFFFF_0003_0002_0001, 64'h0001_0001_0001_0001, 16'h0, 2'd0, 6'd5);
      chk("vadd_valid", out_valid, 1);
      chk("vadd_dest",  vec_dest, 64'h0000_0004_0003_0002);
      chk("vadd_idx",   dest_idx, 5);
      chk("vadd_wen",   wen, 1);
      chk("vadd_ready", ready, 1);
      tick();
      chk("idle_valid", out_valid, 0);
      chk("idle_wen",   wen, 0);

      // signed boundary cases
      issue(OP_VADD, 64'h0000_0000_8000_7FFF, 64'h0000_0000_FFFF_0001, 16'h0, 2'd0, 6'd6);
`ifdef VEC_EXEC_SATURATE_EN
      chk("vadd_bound", vec_dest, 64'h0000_0000_8000_7FFF);
`else
      chk("vadd_bound", vec_dest, 64'h0000_0000_7FFF_8000);
`endif
      issue(OP_VSUB, 64'h0000_0000_0005_8000, 64'h0000_0000_0007_0001, 16'h0, 2'd0, 6'd7);
`ifdef VEC_EXEC_SATURATE_EN
      chk("vsub_bound", vec_dest, 64'h0000_0000_FFFE_8000);
`else
      chk("vsub_bound", vec_dest, 64'h0000_0000_FFFE_7FFF);
`endif
      chk("vsub_idx", dest_idx, 7);

      issue(OP_VCOMPMOV, 64'h0, 64'h0, 16'hABCD, 2'd2, 6'd8);
      chk("vcompmov_zero", vec_dest, 64'h0000_ABCD_0000_0000);
      issue(OP_VCOMPMOV, 64'h1111_2222_3333_4444, 64'h0, 16'hABCD, 2'd0, 6'd8);
      chk("vcompmov_l0", vec_dest, 64'h1111_2222_3333_ABCD);
      issue(OP_VMOVI, 64'h1234_1234_1234_1234, 64'h0, 16'h0005, 2'd0, 6'd9);
      chk("vmovi_dest", vec_dest, 64'h0005_0005_0005_0005);

      // reserved opcodes
      issue(3'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 2'd1, 6'd10);
      chk("rsv6_valid", out_valid, 1);
      chk("rsv6_wen",   wen, 0);
      chk("rsv6_dest",  vec_dest, 0);
      issue(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 16'h1, 2'd1, 6'd11);
      chk("rsv7_wen",   wen, 0);
      tick();

      // four back-to-back VANDs
      for (int k = 0; k < 4; k++) begin
         issue(OP_VAND, 64'h1234_5678_9ABC_DEF0, vand_b[k], 16'h0, 2'd0, 6'(10 + k));
         chk("vand_valid", out_valid, 1);
         chk("vand_dest",  vec_dest, vand_exp[k]);
         chk("vand_idx",   dest_idx, 10 + k);
      end
      tick();
      chk("vand_drain", out_valid, 0);

      // VMUL, full latency
      issue(OP_VMUL, 64'hFFFF_0100_0007_0003, 64'h0002_0100_0009_0005, 16'h0, 2'd0, 6'd20);
      cnt_ok = 0;
      if (busy && !ready && !out_valid) cnt_ok++;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (busy && !ready && !out_valid) cnt_ok++;
      end
      chk("vmul_busy_cycles", cnt_ok, 16);
      tick();
      chk("vmul_valid", out_valid, 1);
      chk("vmul_dest",  vec_dest, 64'hFFFE_0000_003F_000F);
      chk("vmul_idx",   dest_idx, 20);
      chk("vmul_wen",   wen, 1);
      chk("vmul_busy_end", busy, 0);
      chk("vmul_ready_end", ready, 1);
      tick();
      chk("vmul_drain", out_valid, 0);

      // stall holds a result; a pending op waits for ready
      issue(OP_VMOVI, 64'h0, 64'h0, 16'h0009, 2'd0, 6'd3);
      stall = 1'b1;
      in_valid = 1'b1; op = OP_VMOVI; scalar = 16'h0007; dst = 6'd4;
      #1;
      chk("stall_ready", ready, 0);
      cnt_ok = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (out_valid && vec_dest == 64'h0009_0009_0009_0009 && dest_idx == 6'd3 && wen && !ready)
            cnt_ok++;
      end
      chk("stall_hold_cycles", cnt_ok, 3);
      stall = 1'b0;
      #1;
      chk("unstall_ready", ready, 1);
      tick();
      in_valid = 1'b0;
      chk("after_stall_dest", vec_dest, 64'h0007_0007_0007_0007);
      chk("after_stall_idx",  dest_idx, 4);
      tick();
      chk("after_stall_drain", out_valid, 0);

      // VMUL finishing under stall
      issue(OP_VMUL, 64'h0005_0004_0003_0002, 64'h000A_000A_000A_000A, 16'h0, 2'd0, 6'd21);
      for (int k = 0; k < 15; k++) tick();
      stall = 1'b1;
      tick();
      chk("mulstall_valid0", out_valid, 0);
      chk("mulstall_busy0",  busy, 1);
      tick();
      chk("mulstall_valid1", out_valid, 0);
      stall = 1'b0;
      tick();
      chk("mulstall_valid", out_valid, 1);
      chk("mulstall_dest",  vec_dest, 64'h0032_0028_001E_0014);
      chk("mulstall_idx",   dest_idx, 21);
      tick();

      // reset in the middle of a VMUL
      issue(OP_VMUL, 64'hFFFF_0100_0007_0003, 64'h0002_0100_0009_0005, 16'h0, 2'd0, 6'd22);
      for (int k = 0; k < 5; k++) tick();
      chk("midrst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy",  busy, 0);
      chk("midrst_ready", ready, 0);
      chk("midrst_dest",  vec_dest, 0);
      chk("midrst_idx",   dest_idx, 0);
      chk("midrst_valid", out_valid, 0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("midrst_release_ready", ready, 1);
      cnt_v = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid || busy) cnt_v++;
      end
      chk("midrst_no_stale", cnt_v, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
